mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 109 ++++++++++
 tb/tb_mux_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Two-requester grant arbiter with registered grants/select and a combinational data mux.
// Optional hold timeout forcing a hand-over is enabled by defining MUX_ARBITER_TIMEOUT_EN.
module mux_arbiter #(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_x,
  input  logic              req_y,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic              gnt_x,
  output logic              gnt_y,
  output logic              sel,
  output logic [DATA_W-1:0] m,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GX   = 2'd1,
    GY   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_MAX);

  state_t     state;
  state_t     state_nx;
  logic       last_y;
  logic       sel_q;
  logic [3:0] cnt;
  logic       expired;

  always_comb begin
`ifdef MUX_ARBITER_TIMEOUT_EN
    expired = (cnt == HOLD);
`else
    expired = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last_y <= 1'b1;
      sel_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      // Rewriting last_y/sel every cycle a grant is held equals updating them on entry only.
      if (state_nx == GX) begin
        last_y <= 1'b0;
        sel_q  <= 1'b0;
      end else if (state_nx == GY) begin
        last_y <= 1'b1;
        sel_q  <= 1'b1;
      end
      if (state_nx == IDLE)
        cnt <= '0;
      else if (state_nx != state)
        cnt <= 4'd1;
      else if (cnt < HOLD)
        cnt <= cnt + 4'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_x && (!req_y || last_y))
          state_nx = GX;
        else if (req_y)
          state_nx = GY;
      end
      GX: begin
        if (req_x && !(expired && req_y))
          state_nx = GX;
        else if (req_y)
          state_nx = GY;
        else
          state_nx = IDLE;
      end
      GY: begin
        if (req_y && !(expired && req_x))
          state_nx = GY;
        else if (req_x)
          state_nx = GX;
        else
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_x = (state == GX);
    gnt_y = (state == GY);
    sel   = sel_q;
    busy  = gnt_x | gnt_y;
    unique case (state)
      GX:      m = x;
      GY:      m = y;
      default: m = '0;
    endcase
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: a behavioural model pushes expected outputs per cycle,
// each scenario task pops and compares after the clock edge.
module tb_mux_arbiter;
  localparam int DW = 8;
  localparam int HM = 4;
`ifdef MUX_ARBITER_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_x, req_y;
  logic [DW-1:0] x, y, m;
  logic          gnt_x, gnt_y, sel, busy;

  typedef struct packed {
    logic          gx;
    logic          gy;
    logic          s;
    logic          b;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   errors  = 0;

  int mst;
  bit mlast_y;
  int mcnt;
  bit msel;

  always #5 clk = ~clk;

  mux_arbiter #(.DATA_W(DW), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset), .req_x(req_x), .req_y(req_y), .x(x), .y(y),
    .gnt_x(gnt_x), .gnt_y(gnt_y), .sel(sel), .m(m), .busy(busy)
  );

  task automatic model_reset();
    mst = 0; mlast_y = 1'b1; mcnt = 0; msel = 1'b0;
  endtask

  task automatic drive(input logic rx, input logic ry);
    int   nst;
    bit   forced;
    exp_t e;
    req_x = rx; req_y = ry;
    x = DW'($urandom); y = DW'($urandom);
    nst = 0;
    case (mst)
      0: begin
        if (rx && ry)  nst = mlast_y ? 1 : 2;
        else if (rx)   nst = 1;
        else if (ry)   nst = 2;
      end
      1: begin
        forced = TMO && (mcnt == HM) && ry;
        if (rx && !forced) nst = 1;
        else if (ry)       nst = 2;
      end
      default: begin
        forced = TMO && (mcnt == HM) && rx;
        if (ry && !forced) nst = 2;
        else if (rx)       nst = 1;
      end
    endcase
    if (nst == 0)        mcnt = 0;
    else if (nst != mst) mcnt = 1;
    else if (mcnt < HM)  mcnt = mcnt + 1;
    if (nst == 1) begin mlast_y = 1'b0; msel = 1'b0; end
    if (nst == 2) begin mlast_y = 1'b1; msel = 1'b1; end
    mst  = nst;
    e.gx = (nst == 1);
    e.gy = (nst == 2);
    e.s  = msel;
    e.b  = e.gx | e.gy;
    e.d  = e.gx ? x : (e.gy ? y : '0);
    sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t got, ex;
    reset = 1'b1; req_x = 1'b0; req_y = 1'b0; x = '1; y = '1;
    model_reset();
    @(posedge clk); #1;
    vectors++;
    if ({gnt_x, gnt_y, sel, busy, m} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h exp 0", {gnt_x, gnt_y, sel, busy, m});
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0);
      got = {gnt_x, gnt_y, sel, busy, m}; ex = sbq.pop_front(); vectors++;
      if (got !== ex) begin errors++; $display("FAIL reset_idle: got %h exp %h", got, ex); end
    end
  endtask

  task automatic test_tie();
    exp_t got, ex;
    logic [1:0] seq [6] = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11};
    for (int i = 0; i < 6; i++) begin
      drive(seq[i][1], seq[i][0]);
      got = {gnt_x, gnt_y, sel, busy, m}; ex = sbq.pop_front(); vectors++;
      if (got !== ex) begin errors++; $display("FAIL tie[%0d]: got %h exp %h", i, got, ex); end
    end
    drive(1'b0, 1'b0);
    got = {gnt_x, gnt_y, sel, busy, m}; ex = sbq.pop_front(); vectors++;
    if (got !== ex) begin errors++; $display("FAIL tie_release: got %h exp %h", got, ex); end
  endtask

  task automatic test_switch();
    exp_t got, ex;
    logic [1:0] seq [7] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 7; i++) begin
      drive(seq[i][1], seq[i][0]);
      got = {gnt_x, gnt_y, sel, busy, m}; ex = sbq.pop_front(); vectors++;
      if (got !== ex) begin errors++; $display("FAIL switch[%0d]: got %h exp %h", i, got, ex); end
    end
  endtask

  task automatic test_hold();
    exp_t got, ex;
    int   xcnt = 0;
    drive(1'b1, 1'b0);
    got = {gnt_x, gnt_y, sel, busy, m}; ex = sbq.pop_front(); vectors++;
    if (got !== ex) begin errors++; $display("FAIL hold_start: got %h exp %h", got, ex); end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1);
      if (gnt_x) xcnt++;
      got = {gnt_x, gnt_y, sel, busy, m}; ex = sbq.pop_front(); vectors++;
      if (got !== ex) begin errors++; $display("FAIL hold[%0d]: got %h exp %h", i, got, ex); end
    end
`ifdef MUX_ARBITER_TIMEOUT_EN
    vectors++;
    if (xcnt != 11) begin errors++; $display("FAIL hold_alternate: got %0d x-cycles exp 11", xcnt); end
`else
    vectors++;
    if (xcnt != 20) begin errors++; $display("FAIL hold_no_timeout: got %0d x-cycles exp 20", xcnt); end
`endif
    drive(1'b0, 1'b0);
    got = {gnt_x, gnt_y, sel, busy, m}; ex = sbq.pop_front(); vectors++;
    if (got !== ex) begin errors++; $display("FAIL hold_release: got %h exp %h", got, ex); end
  endtask

  task automatic test_async_reset();
    exp_t got, ex;
    drive(1'b0, 1'b1);
    got = {gnt_x, gnt_y, sel, busy, m}; ex = sbq.pop_front(); vectors++;
    if (got !== ex) begin errors++; $display("FAIL async_gy: got %h exp %h", got, ex); end
    y = DW'(1);
    #1;
    vectors++;
    if (m !== DW'(1)) begin errors++; $display("FAIL async_m_before: got %h exp 01", m); end
    reset = 1'b1;
    #1;
    vectors++;
    if ({gnt_x, gnt_y, sel, busy, m} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h exp 0", {gnt_x, gnt_y, sel, busy, m});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1);
    got = {gnt_x, gnt_y, sel, busy, m}; ex = sbq.pop_front(); vectors++;
    if (got !== ex) begin errors++; $display("FAIL post_reset_tie: got %h exp %h", got, ex); end
  endtask

  task automatic test_random();
    exp_t got, ex;
    int   wx = 0, wy = 0;
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      got = {gnt_x, gnt_y, sel, busy, m}; ex = sbq.pop_front(); vectors++;
      if (got !== ex) begin errors++; $display("FAIL random[%0d]: got %h exp %h", i, got, ex); end
      vectors++;
      if (gnt_x && gnt_y) begin errors++; $display("FAIL random_excl[%0d]: got 11 exp not both", i); end
      wx = (req_x && !gnt_x) ? wx + 1 : 0;
      wy = (req_y && !gnt_y) ? wy + 1 : 0;
`ifdef MUX_ARBITER_TIMEOUT_EN
      vectors++;
      if (wx > HM + 1 || wy > HM + 1) begin
        errors++;
        $display("FAIL random_starve[%0d]: got waits x=%0d y=%0d exp <= %0d", i, wx, wy, HM + 1);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_switch();
    test_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
